or1200_insn_monitor: RTL and testbench

Passive instruction-retire monitor for the OR1200 write-back stage inside the orpsoc system. It watches the instruction leaving the write-back stage and counts retired instructions. It also decodes the simulation-control `l.nop K` instructions (exit, report, putc) and presents their results as registered status outputs. It drives nothing back into the CPU.

---
 rtl/or1200_insn_monitor.sv | 84 ++++++++
 tb/tb_or1200_insn_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/or1200_insn_monitor.sv
// Passive retire monitor for the OR1200 write-back stage: counts retired instructions and
// decodes the l.nop exit/report/putc codes. Define OR1200_MONITOR_SIM_EN for simulation console output.
module or1200_insn_monitor #(
    parameter logic [31:0] BUBBLE_INSN = 32'h1441_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_insn,
    input  logic        wb_freeze,
    input  logic [31:0] r3_val,
    output logic [31:0] insn_count,
    output logic        report_valid,
    output logic [31:0] report_data,
    output logic        putc_valid,
    output logic [7:0]  putc_char,
    output logic        exit_flag,
    output logic [31:0] exit_code
);

    localparam logic [15:0] K_EXIT   = 16'h0001;
    localparam logic [15:0] K_REPORT = 16'h0002;
    localparam logic [15:0] K_PUTC   = 16'h0004;

    logic        retire;
    logic        is_nop;
    logic [15:0] nop_k;

    // A frozen instruction is seen again once the freeze drops, so it retires exactly once.
    assign retire = !wb_freeze && (wb_insn != BUBBLE_INSN) && !exit_flag;
    assign is_nop = (wb_insn[31:24] == 8'h15);
    assign nop_k  = wb_insn[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count   <= 32'h0;
            report_valid <= 1'b0;
            report_data  <= 32'h0;
            putc_valid   <= 1'b0;
            putc_char    <= 8'h0;
            exit_flag    <= 1'b0;
            exit_code    <= 32'h0;
        end else begin
            report_valid <= 1'b0;
            putc_valid   <= 1'b0;
            if (retire) begin
                insn_count <= insn_count + 32'd1;
                if (is_nop) begin
                    case (nop_k)
                        K_EXIT: begin
                            exit_flag <= 1'b1;
                            exit_code <= r3_val;
                        end
                        K_REPORT: begin
                            report_valid <= 1'b1;
                            report_data  <= r3_val;
                        end
                        K_PUTC: begin
                            putc_valid <= 1'b1;
                            putc_char  <= r3_val[7:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef OR1200_MONITOR_SIM_EN
    always @(posedge clk) begin
        if (rst_n && retire && is_nop) begin
            case (nop_k)
                K_REPORT: $display("report(0x%08h);", r3_val);
                K_PUTC:   $write("%c", r3_val[7:0]);
                K_EXIT: begin
                    $display("exit(0x%08h)", r3_val);
                    $finish;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_or1200_insn_monitor.sv
// Bench for or1200_insn_monitor: directed scenarios plus randomized traffic against a
// behavioural model, with one compare process checking every output on each falling edge.
module tb_or1200_insn_monitor;

    localparam logic [31:0] BUBBLE = 32'h1441_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_insn;
    logic        wb_freeze;
    logic [31:0] r3_val;
    logic [31:0] insn_count;
    logic        report_valid;
    logic [31:0] report_data;
    logic        putc_valid;
    logic [7:0]  putc_char;
    logic        exit_flag;
    logic [31:0] exit_code;

    int n_checks;
    int n_fail;
    bit check_en;

    or1200_insn_monitor #(.BUBBLE_INSN(BUBBLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_insn     (wb_insn),
        .wb_freeze   (wb_freeze),
        .r3_val      (r3_val),
        .insn_count  (insn_count),
        .report_valid(report_valid),
        .report_data (report_data),
        .putc_valid  (putc_valid),
        .putc_char   (putc_char),
        .exit_flag   (exit_flag),
        .exit_code   (exit_code)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_count;
    bit          m_report_v;
    logic [31:0] m_report_d;
    bit          m_putc_v;
    logic [7:0]  m_putc_c;
    bit          m_exit;
    logic [31:0] m_exit_code;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0; m_report_v = 0; m_report_d = 0;
            m_putc_v = 0; m_putc_c = 0; m_exit = 0; m_exit_code = 0;
        end else begin
            m_report_v = 0;
            m_putc_v   = 0;
            if (!wb_freeze && wb_insn != BUBBLE && !m_exit) begin
                m_count = m_count + 1;
                if (wb_insn[31:24] == 8'h15) begin
                    if (wb_insn[15:0] == 16'd1) begin m_exit = 1; m_exit_code = r3_val; end
                    if (wb_insn[15:0] == 16'd2) begin m_report_v = 1; m_report_d = r3_val; end
                    if (wb_insn[15:0] == 16'd4) begin m_putc_v = 1; m_putc_c = r3_val[7:0]; end
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cmp insn_count", insn_count, m_count);
            chk("cmp report_valid", {31'b0, report_valid}, {31'b0, m_report_v});
            chk("cmp report_data", report_data, m_report_d);
            chk("cmp putc_valid", {31'b0, putc_valid}, {31'b0, m_putc_v});
            chk("cmp putc_char", {24'b0, putc_char}, {24'b0, m_putc_c});
            chk("cmp exit_flag", {31'b0, exit_flag}, {31'b0, m_exit});
            chk("cmp exit_code", exit_code, m_exit_code);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic [31:0] insn, input logic frz, input logic [31:0] r3);
        wb_insn   = insn;
        wb_freeze = frz;
        r3_val    = r3;
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " count"}, insn_count, 32'h0);
        chk({tag, " rv"}, {31'b0, report_valid}, 32'h0);
        chk({tag, " rd"}, report_data, 32'h0);
        chk({tag, " pv"}, {31'b0, putc_valid}, 32'h0);
        chk({tag, " pc"}, {24'b0, putc_char}, 32'h0);
        chk({tag, " ef"}, {31'b0, exit_flag}, 32'h0);
        chk({tag, " ec"}, exit_code, 32'h0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; check_en = 0;
        rst_n = 0; wb_insn = $urandom; wb_freeze = 0; r3_val = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_insn = $urandom; r3_val = $urandom;
        end
        all_zero("reset");
        check_en = 1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) step(32'hE000_0000, 0, $urandom);
        chk("five retires", insn_count, 32'd5);

        for (int i = 0; i < 3; i++) step(32'h9C21_0004, 1, 0);
        chk("stall held", insn_count, 32'd5);
        step(32'h9C21_0004, 0, 0);
        chk("stall released", insn_count, 32'd6);
        for (int i = 0; i < 10; i++) step(BUBBLE, 0, $urandom);
        chk("bubbles", insn_count, 32'd6);

        step(32'h1500_0002, 0, 32'hDEAD_BEEF);
        chk("report1 valid", {31'b0, report_valid}, 32'd1);
        chk("report1 data", report_data, 32'hDEAD_BEEF);
        step(32'h1500_0002, 0, 32'h1234_5678);
        chk("report2 valid", {31'b0, report_valid}, 32'd1);
        chk("report2 data", report_data, 32'h1234_5678);
        step(BUBBLE, 0, 0);
        chk("report end valid", {31'b0, report_valid}, 32'd0);
        chk("report hold data", report_data, 32'h1234_5678);

        step(32'h1500_0004, 0, 32'h0000_0148);
        chk("putc valid", {31'b0, putc_valid}, 32'd1);
        chk("putc char", {24'b0, putc_char}, 32'h48);
        step(32'h1500_0007, 0, 32'h0000_0055);
        chk("nop7 no pulse", {31'b0, putc_valid}, 32'd0);
        chk("nop7 count", insn_count, 32'd10);

        step(32'h1500_0001, 0, 32'h0000_002A);
        chk("exit flag", {31'b0, exit_flag}, 32'd1);
        chk("exit code", exit_code, 32'h2A);
        chk("exit counted", insn_count, 32'd11);
        step(32'h1500_0004, 0, 32'h0000_0061);
        step(32'h1500_0002, 0, 32'h0000_0077);
        step(32'hE000_0000, 0, 0);
        chk("post-exit count", insn_count, 32'd11);
        chk("post-exit putc", {24'b0, putc_char}, 32'h48);
        chk("post-exit report", report_data, 32'h1234_5678);

        #2 rst_n = 0;
        #1 all_zero("async reset");
        @(negedge clk);
        rst_n = 1; wb_insn = 32'h1500_0001; wb_freeze = 0; r3_val = 32'h0000_0055;
        @(negedge clk);
        chk("exit on release flag", {31'b0, exit_flag}, 32'd1);
        chk("exit on release code", exit_code, 32'h55);
        chk("exit on release count", insn_count, 32'd1);

        // Wrap: preload the counter rather than retiring 2^32-1 instructions.
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        step(BUBBLE, 0, 0);
        check_en = 0;
        force dut.insn_count = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        #1 release dut.insn_count;
        check_en = 1;
        step(32'hE000_0000, 0, 0);
        chk("wrap", insn_count, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            int sel;
            logic [31:0] insn;
            sel = $urandom_range(0, 99);
            if (sel < 30)      insn = $urandom;
            else if (sel < 45) insn = BUBBLE;
            else if (sel < 60) insn = 32'h1500_0002;
            else if (sel < 75) insn = 32'h1500_0004;
            else if (sel < 77) insn = 32'h1500_0001;
            else if (sel < 90) insn = {8'h15, 8'($urandom), 16'($urandom_range(0, 8))};
            else               insn = 32'h9C21_0004;
            step(insn, ($urandom_range(0, 3) == 0), $urandom);
            if ((m_exit && $urandom_range(0, 9) == 0) || $urandom_range(0, 199) == 0) begin
                #($urandom_range(1, 8)) rst_n = 0;
                #1 all_zero("rand reset");
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
